// File: rtl/cr_lz77_comp_pkg.sv
// Shared types for the LZ77 compressor: TLV bus word and LOB arbiter state encoding.
package cr_lz77_comp_pkg;

    // TLV word passed between compressor stages.
    typedef struct packed {
        logic        insert;
        logic [7:0]  ordern;
        logic [4:0]  typen;
        logic        sot;
        logic        eot;
        logic        tlast;
        logic [1:0]  tid;
        logic [7:0]  tstrb;
        logic [7:0]  tuser;
        logic [63:0] tdata;
    } tlvp_if_bus_t;

    // LOB arbiter state encoding.
    localparam logic [1:0] LOB_ARB_ST_IDLE = 2'd0;
    localparam logic [1:0] LOB_ARB_ST_OWN0 = 2'd1;
    localparam logic [1:0] LOB_ARB_ST_OWN1 = 2'd2;

    typedef enum logic [1:0] {
        StIdle = LOB_ARB_ST_IDLE,
        StOwn0 = LOB_ARB_ST_OWN0,
        StOwn1 = LOB_ARB_ST_OWN1
    } lob_arb_st_e;

endpackage

// File: rtl/cr_lz77_comp_lob_arb.sv
// Two-requester frame arbiter merging TLV words into the parser input.
// A port owns the output from its first accepted word until its eot word.
// Optional build macro CR_LZ77_COMP_LOB_ARB_STATS_EN adds per-port frame counters.
module cr_lz77_comp_lob_arb
    import cr_lz77_comp_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         exg0_req,
    input  logic         exg1_req,
    input  logic         exg0_wr,
    input  logic         exg1_wr,
    input  tlvp_if_bus_t exg0_tlv_if,
    input  tlvp_if_bus_t exg1_tlv_if,
    output logic         exg0_afull,
    output logic         exg1_afull,
    input  logic         prs_lob_afull,
    output logic         lob_prs_wr,
    output tlvp_if_bus_t lob_prs_tlv_if,
    output logic         arb_wr_err,
    output logic         arb_stall_err
`ifdef CR_LZ77_COMP_LOB_ARB_STATS_EN
    ,
    output logic [31:0]  arb_frm_cnt0,
    output logic [31:0]  arb_frm_cnt1
`endif
);

    localparam logic [15:0] StallLim = 16'(STALL_LIMIT);

    lob_arb_st_e  arb_st;
    logic         last_gnt;
    logic [15:0]  stall_cnt;

    logic         sel_vld;
    logic         sel_port;
    logic         acc0;
    logic         acc1;
    logic         acc;
    tlvp_if_bus_t acc_tlv;
    logic         bad_wr;
    logic         stall_inc;

    // Port selection, write acceptance and stall qualification.
    always_comb begin
        sel_vld  = 1'b0;
        sel_port = 1'b0;
        unique case (arb_st)
            StIdle: begin
                if (exg0_req && exg1_req) begin
                    sel_vld  = 1'b1;
                    sel_port = ~last_gnt;
                end else if (exg0_req) begin
                    sel_vld  = 1'b1;
                    sel_port = 1'b0;
                end else if (exg1_req) begin
                    sel_vld  = 1'b1;
                    sel_port = 1'b1;
                end
            end
            StOwn0: begin
                sel_vld  = 1'b1;
                sel_port = 1'b0;
            end
            StOwn1: begin
                sel_vld  = 1'b1;
                sel_port = 1'b1;
            end
            default: begin
                sel_vld  = 1'b0;
                sel_port = 1'b0;
            end
        endcase

        acc0    = exg0_wr & sel_vld & ~sel_port;
        acc1    = exg1_wr & sel_vld & sel_port;
        acc     = acc0 | acc1;
        acc_tlv = acc1 ? exg1_tlv_if : exg0_tlv_if;
        bad_wr  = (exg0_wr & ~acc0) | (exg1_wr & ~acc1);

        // Back-pressure from the parser freezes the stall count.
        stall_inc = ~prs_lob_afull &
                    (((arb_st == StOwn0) & ~exg0_wr) | ((arb_st == StOwn1) & ~exg1_wr));

        exg0_afull = prs_lob_afull | ~(sel_vld & ~sel_port);
        exg1_afull = prs_lob_afull | ~(sel_vld & sel_port);
    end

    // Ownership FSM, registered parser write, stall counter and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_st         <= StIdle;
            last_gnt       <= 1'b1;
            lob_prs_wr     <= 1'b0;
            lob_prs_tlv_if <= '0;
            stall_cnt      <= 16'd0;
            arb_wr_err     <= 1'b0;
            arb_stall_err  <= 1'b0;
        end else begin
            lob_prs_wr <= acc;
            if (acc) begin
                lob_prs_tlv_if <= acc_tlv;
                if (acc_tlv.eot) begin
                    arb_st   <= StIdle;
                    last_gnt <= sel_port;
                end else begin
                    arb_st <= sel_port ? StOwn1 : StOwn0;
                end
            end

            if (acc || arb_st == StIdle) begin
                stall_cnt <= 16'd0;
            end else if (stall_inc && stall_cnt != StallLim) begin
                stall_cnt <= stall_cnt + 16'd1;
                if (stall_cnt + 16'd1 == StallLim) begin
                    arb_stall_err <= 1'b1;
                end
            end

            if (bad_wr) begin
                arb_wr_err <= 1'b1;
            end
        end
    end

`ifdef CR_LZ77_COMP_LOB_ARB_STATS_EN
    // Per-port count of completed frames (accepted eot words), wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_frm_cnt0 <= 32'd0;
            arb_frm_cnt1 <= 32'd0;
        end else begin
            if (acc0 && exg0_tlv_if.eot) begin
                arb_frm_cnt0 <= arb_frm_cnt0 + 32'd1;
            end
            if (acc1 && exg1_tlv_if.eot) begin
                arb_frm_cnt1 <= arb_frm_cnt1 + 32'd1;
            end
        end
    end
`endif

endmodule
